// File: rtl/spi_frame_rx.sv
// spi_frame_rx: oversampled SPI frame receiver presenting 16-bit or config-byte frames; macro SPI_FRAME_RX_TIMEOUT_EN adds a CS-low stall abort
module spi_frame_rx #(parameter int unsigned TIMEOUT_CYCLES = 4800000) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sck,
  input  logic       csN,
  input  logic       sdi,
  output logic       ready,
  output logic [7:0] spiPacket1,
  output logic [7:0] spiPacket2,
  output logic       frameErr
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;
  logic [2:0] sck_q, csn_q, sdi_q;
  logic sck_rise_q, cs_fall_q, cs_rise_q;
  logic [0:0] state_q, state_d;
  logic [15:0] shift_q, shift_d, sh;
  logic [4:0] cnt_q, cnt_d, cn;
  logic ready_q, ready_d, err_q, err_d, ok16, ok8;
  logic [7:0] pkt1_q, pkt1_d, pkt2_q, pkt2_d;
`ifdef SPI_FRAME_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sck_q <= '0;
      csn_q <= '0;
      sdi_q <= '0;
      sck_rise_q <= 1'b0;
      cs_fall_q <= 1'b0;
      cs_rise_q <= 1'b0;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      csn_q <= {csn_q[1:0], csN};
      sdi_q <= {sdi_q[1:0], sdi};
      sck_rise_q <= sck_q[1] & ~sck_q[2];
      cs_fall_q <= ~csn_q[1] & csn_q[2];
      cs_rise_q <= csn_q[1] & ~csn_q[2];
    end
  always_comb begin
    sh = sck_rise_q ? {shift_q[14:0], sdi_q[2]} : shift_q;
    cn = (sck_rise_q && cnt_q != 5'd17) ? cnt_q + 5'd1 : cnt_q;
    ok16 = cn == 5'd16;
    ok8 = cn == 5'd8 && sh[7:5] == 3'b111;
    state_d = state_q;
    shift_d = shift_q;
    cnt_d = cnt_q;
    ready_d = 1'b0;
    err_d = 1'b0;
    pkt1_d = pkt1_q;
    pkt2_d = pkt2_q;
`ifdef SPI_FRAME_RX_TIMEOUT_EN
    tmo_d = '0;
`endif
    if (state_q == IDLE) begin
      if (cs_fall_q) begin
        state_d = RECV;
        shift_d = '0;
        cnt_d = '0;
      end
    end else begin
      shift_d = sh;
      cnt_d = cn;
`ifdef SPI_FRAME_RX_TIMEOUT_EN
      tmo_d = sck_rise_q ? '0 : tmo_q + 1'b1;
`endif
      if (cs_rise_q) begin
        state_d = IDLE;
        ready_d = ok16 | ok8;
        err_d = !ok16 && !ok8 && cn != 5'd0;
        pkt1_d = ok16 ? sh[15:8] : ok8 ? sh[7:0] : pkt1_q;
        pkt2_d = ok16 ? sh[7:0] : ok8 ? 8'h00 : pkt2_q;
      end
`ifdef SPI_FRAME_RX_TIMEOUT_EN
      else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
        state_d = IDLE;
        err_d = 1'b1;
      end
`endif
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q <= '0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
      pkt1_q <= '0;
      pkt2_q <= '0;
`ifdef SPI_FRAME_RX_TIMEOUT_EN
      tmo_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
      err_q <= err_d;
      pkt1_q <= pkt1_d;
      pkt2_q <= pkt2_d;
`ifdef SPI_FRAME_RX_TIMEOUT_EN
      tmo_q <= tmo_d;
`endif
    end
  assign ready = ready_q;
  assign frameErr = err_q;
  assign spiPacket1 = pkt1_q;
  assign spiPacket2 = pkt2_q;
endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx: randomized and directed frames checked against a frame-level reference model
module tb_spi_frame_rx;
  logic clk = 1'b0, reset_n = 1'b0, sck = 1'b0, csN = 1'b1, sdi = 1'b0;
  logic ready, frameErr;
  logic [7:0] p1, p2;
  int checks = 0, errors = 0, cyc = 0, last_rise = 0, overlap = 0;
  logic [7:0] exp_p1 = 8'h00, exp_p2 = 8'h00;
  logic [15:0] acc_q[$];
  spi_frame_rx #(.TIMEOUT_CYCLES(100)) dut (.clk(clk), .reset_n(reset_n), .sck(sck), .csN(csN), .sdi(sdi),
       .ready(ready), .spiPacket1(p1), .spiPacket2(p2), .frameErr(frameErr));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (ready && frameErr) overlap++;
    if (ready) acc_q.push_back({p1, p2});
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [31:0] d, input int n, output int kind);
    if (n == 0) kind = 0;
    else if (n == 16) begin
      kind = 1;
      exp_p1 = d[15:8];
      exp_p2 = d[7:0];
    end else if (n == 8 && d[7:5] == 3'b111) begin
      kind = 1;
      exp_p1 = d[7:0];
      exp_p2 = 8'h00;
    end else kind = 2;
  endtask
  task automatic cs_low();
    csN = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic send_bits(input logic [31:0] d, input int n, input int from);
    for (int i = from; i < n; i++) begin
      sdi = d[n-1-i];
      sck = 1'b0;
      repeat (2) @(negedge clk);
      sck = 1'b1;
      last_rise = cyc;
      repeat (2) @(negedge clk);
    end
    sck = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic cs_high_check(input string tag, input int kind);
    int first, nr, ne;
    first = 0; nr = 0; ne = 0;
    csN = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ready) begin nr++; if (first == 0) first = i; end
      if (frameErr) begin ne++; if (first == 0) first = i; end
    end
    check({tag, "_ready"}, nr, (kind == 1) ? 1 : 0);
    check({tag, "_err"}, ne, (kind == 2) ? 1 : 0);
    if (kind != 0) check({tag, "_latency"}, first, 4);
    check({tag, "_pkt"}, {p1, p2}, {exp_p1, exp_p2});
  endtask
  task automatic frame(input string tag, input logic [31:0] d, input int n);
    int kind;
    cs_low();
    send_bits(d, n, 0);
    model(d, n, kind);
    cs_high_check(tag, kind);
  endtask
  initial begin
    int kind, nr, ne, err_at, sz;
    logic [31:0] d;
    int n;
    repeat (3) @(negedge clk);
    check("reset_out", {ready, frameErr, p1, p2}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    frame("f16", 32'h1234, 16);
    frame("cfg", 32'hE5, 8);
    frame("cfg_bad", 32'h45, 8);
    frame("len17", 32'h1ABCD, 17);
    frame("len12", 32'hABC, 12);
    frame("len0", 32'h0, 0);
    sz = acc_q.size();
    cs_low();
    send_bits(32'hAA55, 16, 0);
    csN = 1'b1;
    repeat (2) @(negedge clk);
    cs_low();
    send_bits(32'h0FF0, 16, 0);
    csN = 1'b1;
    repeat (8) @(negedge clk);
    check("b2b_count", acc_q.size() - sz, 2);
    if (acc_q.size() >= sz + 2) begin
      check("b2b_first", acc_q[sz], 16'hAA55);
      check("b2b_second", acc_q[sz+1], 16'h0FF0);
    end
    exp_p1 = 8'h0F; exp_p2 = 8'hF0;
    cs_low();
    send_bits(32'hABCD, 16, 0 + 7);
    reset_n = 1'b0;
    #1;
    check("rst_mid_out", {ready, frameErr, p1, p2}, 0);
    exp_p1 = 8'h00; exp_p2 = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send_bits(32'hABCD, 16, 9);
    cs_high_check("rst_tail", 0);
    frame("post_rst", 32'h0102, 16);
    err_at = 0; ne = 0;
    cs_low();
    send_bits(32'h9, 4, 0);
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (frameErr) begin ne++; if (err_at == 0) err_at = cyc - last_rise; end
    end
`ifdef SPI_FRAME_RX_TIMEOUT_EN
    check("tmo_err", ne, 1);
    check("tmo_window", (err_at >= 100 && err_at <= 110) ? 1 : 0, 1);
    cs_high_check("tmo_cs", 0);
`else
    check("stall_err", ne, 0);
    cs_high_check("stall_cs", 2);
`endif
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0: n = 0;
        1: n = 8;
        2, 5: n = 16;
        3: n = 17;
        default: n = $urandom_range(1, 20);
      endcase
      d = $urandom & ((32'd1 << n) - 1);
      if (n == 8 && $urandom_range(0, 1) == 1) d[7:5] = 3'b111;
      frame("rand", d, n);
    end
    check("overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
